// File: rtl/grid_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_arb_pkg
// Description : Shared definitions for the placement-grid access arbiter:
//               opcodes, the empty-cell marker and the controller state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_arb_pkg;

    // Requester opcodes. The fourth code (2'b11) is reserved and behaves as a read.
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLAIM = 2'b10;

    // Empty-cell marker (all ones). Wider/narrower grids replicate bit 0.
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/grid_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : grid_access_arbiter_if
// Description : Requester-side bus between the placement engines and the
//               grid access arbiter. Vectors are flattened per engine:
//               engine k owns req_op[2k+:2], req_addr[k*ADDR_W+:ADDR_W] and
//               req_wdata[k*DATA_W+:DATA_W].
//   master : engine side  (drives req_*, receives ready/response)
//   slave  : arbiter side (receives req_*, drives ready/response)
// Revision    : 1.0 - initial release
// ============================================================================
interface grid_access_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [2*NREQ-1:0]      req_op;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_ok;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_ok
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_ok
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Returns the first set
//               request searching upward from i_ptr+1 (mod NREQ).
//   i_req   : request vector
//   i_ptr   : index of the last winner
//   o_grant : one-hot grant
//   o_idx   : index of the winner
//   o_any   : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic [NREQ-1:0]  i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [NREQ-1:0]  o_grant,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_any
);

    logic [IDX_W-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = '0;
        // The last winner is visited last, giving it the lowest priority.
        for (int i = 1; i <= NREQ; i++) begin
            w_k = IDX_W'((int'(i_ptr) + i) % NREQ);
            if (!o_any && i_req[w_k]) begin
                o_any        = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/grid_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grid_access_arbiter
// Description : Serialises read / write / claim accesses from NREQ placement
//               engines onto a single-port grid RAM with 1-cycle registered
//               read. A claim writes the id only if the cell holds EMPTY.
//   clk, reset   : clock, asynchronous active-low reset
//   bus          : requester bus (slave modport)
//   mem_*        : grid RAM port (mem_dout valid the cycle after mem_re)
//   busy         : controller not idle
//   conflict_cnt : saturating count of claims that found the cell occupied
// Revision    : 1.0 - initial release
// ============================================================================
module grid_access_arbiter
    import grid_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int GRID_CELLS = 49,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic                clk,
    input  wire logic                reset,
    grid_access_arbiter_if.slave     bus,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_din,
    input  wire logic [DATA_W-1:0]   mem_dout,
    output logic                     busy,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam logic [DATA_W-1:0] c_EMPTY      = {DATA_W{EMPTY[0]}};
    localparam logic [ADDR_W-1:0] c_GRID_CELLS = ADDR_W'(GRID_CELLS);
    localparam logic [NREQ-1:0]   c_ONE        = NREQ'(1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic [1:0]           r_op;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_oor;
    logic                 r_mem_re;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_din;
    logic [NREQ-1:0]      r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;
    logic                 r_rsp_ok;
    logic [CNT_W-1:0]     r_conflict_cnt;

    logic [1:0]           w_op    [NREQ];
    logic [ADDR_W-1:0]    w_addr  [NREQ];
    logic [DATA_W-1:0]    w_wdata [NREQ];
    logic [NREQ-1:0]      w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic [1:0]           w_sel_op;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_sel_oor;
    logic [NREQ-1:0]      w_owner_onehot;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_op[g]    = bus.req_op[2*g +: 2];
            assign w_addr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata[g] = bus.req_wdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_op       = w_op[w_idx];
    assign w_sel_addr     = w_addr[w_idx];
    assign w_sel_wdata    = w_wdata[w_idx];
    assign w_sel_oor      = (w_sel_addr >= c_GRID_CELLS);
    assign w_owner_onehot = c_ONE << r_owner;

    // Accept pulse is combinational so the engine sees it in the grant cycle.
    assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_ok    = r_rsp_ok;
    assign mem_re        = r_mem_re;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_din       = r_mem_din;
    assign busy          = (r_state != ST_IDLE);
    assign conflict_cnt  = r_conflict_cnt;

    // Memory strobes are registered one state ahead: they are set on the
    // transition into the state in which they must be visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= IDX_W'(NREQ - 1);
            r_owner        <= '0;
            r_op           <= OP_READ;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_oor          <= 1'b0;
            r_mem_re       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_din      <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
            r_rsp_ok       <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_idx;
                        r_rr_ptr <= w_idx;
                        r_op     <= w_sel_op;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_oor    <= w_sel_oor;
                        if (!w_sel_oor) begin
                            r_mem_addr <= w_sel_addr;
                            if (w_sel_op == OP_WRITE) begin
                                r_mem_we  <= 1'b1;
                                r_mem_din <= w_sel_wdata;
                            end else begin
                                r_mem_re  <= 1'b1;
                            end
                        end
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_oor) begin
                        r_rsp_ok    <= 1'b0;
                        r_rsp_data  <= c_EMPTY;
                        r_rsp_valid <= w_owner_onehot;
                        r_state     <= ST_RESP;
                    end else if (r_op == OP_WRITE) begin
                        r_rsp_ok    <= 1'b1;
                        r_rsp_valid <= w_owner_onehot;
                        r_state     <= ST_RESP;
                    end else begin
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_rsp_data <= mem_dout;
                    if (r_op == OP_CLAIM) begin
                        // Write-back strobe must be decided now to appear in WB.
                        if (mem_dout == c_EMPTY) begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= r_addr;
                            r_mem_din  <= r_wdata;
                        end
                        r_state <= ST_WB;
                    end else begin
                        r_rsp_ok    <= 1'b1;
                        r_rsp_valid <= w_owner_onehot;
                        r_state     <= ST_RESP;
                    end
                end
                ST_WB: begin
                    if (r_rsp_data == c_EMPTY) begin
                        r_rsp_ok <= 1'b1;
                    end else begin
                        r_rsp_ok <= 1'b0;
                        if (r_conflict_cnt != {CNT_W{1'b1}}) begin
                            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
                        end
                    end
                    r_rsp_valid <= w_owner_onehot;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_access_arbiter
// Description : Directed self-checking bench for grid_access_arbiter with a
//               behavioural 1-cycle registered-read grid RAM. The conflict
//               counter is built narrow (4 bits) so saturation is reachable
//               in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_access_arbiter;
    import grid_arb_pkg::*;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic                clk;
    logic                reset;
    logic                mem_re;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_din;
    logic [DATA_W-1:0]   mem_dout;
    logic                busy;
    logic [CNT_W-1:0]    conflict_cnt;
    logic [DATA_W-1:0]   mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one operation, filled by do_op.
    logic [NREQ-1:0]   obs_ready;
    logic [NREQ-1:0]   obs_rsp_valid;
    logic [DATA_W-1:0] obs_rsp_data;
    logic              obs_ok;
    logic [DATA_W-1:0] obs_din;
    logic [ADDR_W-1:0] obs_re_addr;
    int t_re, t_we, t_rsp, n_re, n_we;

    grid_access_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    grid_access_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRID_CELLS(49), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '1;
        mem_dout = '0;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_addr];
    end

    // Issue one request from engine eng and record what happens over the next
    // cycles; cycle numbers are relative to the grant cycle A.
    task automatic do_op(input int eng, input logic [1:0] op,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        @(negedge clk);
        bus.req_op[2*eng +: 2]              = op;
        bus.req_addr[eng*ADDR_W +: ADDR_W]  = addr;
        bus.req_wdata[eng*DATA_W +: DATA_W] = data;
        bus.req_valid[eng]                  = 1'b1;
        #1;
        obs_ready = bus.req_ready;
        t_re = -1; t_we = -1; t_rsp = -1; n_re = 0; n_we = 0;
        obs_rsp_valid = '0; obs_rsp_data = '0; obs_ok = 1'bx; obs_din = '0; obs_re_addr = '0;
        @(posedge clk); #1;
        bus.req_valid[eng] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_re) begin
                if (t_re < 0) t_re = c;
                n_re++;
                obs_re_addr = mem_addr;
            end
            if (mem_we) begin
                if (t_we < 0) t_we = c;
                n_we++;
                obs_din = mem_din;
            end
            if (|bus.rsp_valid) begin
                t_rsp = c;
                obs_rsp_valid = bus.rsp_valid;
                obs_rsp_data  = bus.rsp_data;
                obs_ok        = bus.rsp_ok;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.req_valid = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        n_checks++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_strobes: got %b expected 00", {mem_re, mem_we}); end
        n_checks++; if (conflict_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_conflict_cnt: got %h expected 0", conflict_cnt); end
        n_checks++; if ({bus.rsp_ok, bus.rsp_data} !== 33'h0) begin n_fail++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_ok, bus.rsp_data}); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_idle: got %b expected 0000", bus.req_ready); end
    endtask

    task automatic test_claim_empty;
        do_op(0, OP_CLAIM, 12'd10, 32'd5);
        n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL claim_ready: got %b expected 0001", obs_ready); end
        n_checks++; if (t_re !== 1 || obs_re_addr !== 12'd10) begin n_fail++; $display("FAIL claim_re: got cycle %0d addr %0d expected cycle 1 addr 10", t_re, obs_re_addr); end
        n_checks++; if (t_we !== 3 || obs_din !== 32'd5) begin n_fail++; $display("FAIL claim_we: got cycle %0d din %0d expected cycle 3 din 5", t_we, obs_din); end
        n_checks++; if (t_rsp !== 4 || obs_rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL claim_rsp: got cycle %0d valid %b expected cycle 4 valid 0001", t_rsp, obs_rsp_valid); end
        n_checks++; if (obs_ok !== 1'b1 || obs_rsp_data !== EMPTY) begin n_fail++; $display("FAIL claim_result: got ok %b data %h expected ok 1 data ffffffff", obs_ok, obs_rsp_data); end
    endtask

    task automatic test_claim_occupied;
        do_op(1, OP_CLAIM, 12'd10, 32'd7);
        n_checks++; if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL occ_ready: got %b expected 0010", obs_ready); end
        n_checks++; if (n_we !== 0) begin n_fail++; $display("FAIL occ_no_write: got %0d writes expected 0", n_we); end
        n_checks++; if (t_rsp !== 4 || obs_rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL occ_rsp: got cycle %0d valid %b expected cycle 4 valid 0010", t_rsp, obs_rsp_valid); end
        n_checks++; if (obs_ok !== 1'b0 || obs_rsp_data !== 32'd5) begin n_fail++; $display("FAIL occ_result: got ok %b data %h expected ok 0 data 5", obs_ok, obs_rsp_data); end
        n_checks++; if (conflict_cnt !== 4'd1) begin n_fail++; $display("FAIL occ_conflict_cnt: got %0d expected 1", conflict_cnt); end
    endtask

    task automatic test_back_to_back;
        int order [4];
        int t_gnt [4];
        int t_rs  [4];
        int n_gnt, n_rsp, idx;
        logic [NREQ-1:0] gmask;
        // Fresh pointer so the first winner is engine 0.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 4; k++) begin order[k] = -1; t_gnt[k] = -100; t_rs[k] = -1; end
        n_gnt = 0; n_rsp = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.req_op[2*k +: 2]              = OP_WRITE;
            bus.req_addr[k*ADDR_W +: ADDR_W]  = ADDR_W'(k);
            bus.req_wdata[k*DATA_W +: DATA_W] = 32'd100 + DATA_W'(k);
        end
        bus.req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 40 && n_rsp < 4; c++) begin
            gmask = bus.req_ready;
            if (|gmask) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (gmask[k]) idx = k;
                if (n_gnt < 4) order[n_gnt] = idx;
                t_gnt[idx] = c;
                n_gnt++;
            end
            if (|bus.rsp_valid) begin
                for (int k = 0; k < 4; k++) if (bus.rsp_valid[k]) t_rs[k] = c;
                n_rsp++;
            end
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid & ~gmask;
            @(negedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (order[k] !== k) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], k); end
            n_checks++; if (t_rs[k] - t_gnt[k] !== 2) begin n_fail++; $display("FAIL rr_latency[%0d]: got %0d expected 2", k, t_rs[k] - t_gnt[k]); end
        end
        n_checks++; if (t_gnt[1] - t_gnt[0] !== 3) begin n_fail++; $display("FAIL rr_spacing: got %0d expected 3", t_gnt[1] - t_gnt[0]); end
        do_op(0, OP_READ, 12'd2, 32'd0);
        n_checks++; if (t_rsp !== 3 || obs_ok !== 1'b1 || obs_rsp_data !== 32'd102) begin n_fail++; $display("FAIL rr_readback: got cycle %0d ok %b data %0d expected cycle 3 ok 1 data 102", t_rsp, obs_ok, obs_rsp_data); end
        // Reserved opcode behaves as a read.
        do_op(1, 2'b11, 12'd3, 32'd55);
        n_checks++; if (n_we !== 0 || t_rsp !== 3 || obs_rsp_data !== 32'd103) begin n_fail++; $display("FAIL reserved_op: got writes %0d cycle %0d data %0d expected writes 0 cycle 3 data 103", n_we, t_rsp, obs_rsp_data); end
    endtask

    task automatic test_out_of_range;
        do_op(3, OP_CLAIM, 12'd49, 32'd9);
        n_checks++; if (n_re !== 0 || n_we !== 0) begin n_fail++; $display("FAIL oor_no_access: got re %0d we %0d expected 0 0", n_re, n_we); end
        n_checks++; if (t_rsp !== 2 || obs_rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL oor_rsp: got cycle %0d valid %b expected cycle 2 valid 1000", t_rsp, obs_rsp_valid); end
        n_checks++; if (obs_ok !== 1'b0 || obs_rsp_data !== EMPTY) begin n_fail++; $display("FAIL oor_result: got ok %b data %h expected ok 0 data ffffffff", obs_ok, obs_rsp_data); end
        // Last valid cell is in range.
        do_op(2, OP_CLAIM, 12'd48, 32'd11);
        n_checks++; if (t_rsp !== 4 || obs_ok !== 1'b1 || t_we !== 3) begin n_fail++; $display("FAIL last_cell_claim: got rsp %0d ok %b we %0d expected rsp 4 ok 1 we 3", t_rsp, obs_ok, t_we); end
    endtask

    task automatic test_reset_in_flight;
        int n_we_seen  = 0;
        int n_rsp_seen = 0;
        @(negedge clk);
        bus.req_op[1:0]     = OP_CLAIM;
        bus.req_addr[11:0]  = 12'd20;
        bus.req_wdata[31:0] = 32'd33;
        bus.req_valid[0]    = 1'b1;
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL inflight_busy: got %b expected 0", busy); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) reset = 1'b1;
            if (mem_we) n_we_seen++;
            if (|bus.rsp_valid) n_rsp_seen++;
        end
        n_checks++; if (n_we_seen !== 0 || n_rsp_seen !== 0) begin n_fail++; $display("FAIL inflight_dropped: got we %0d rsp %0d expected 0 0", n_we_seen, n_rsp_seen); end
        do_op(1, OP_READ, 12'd20, 32'd0);
        n_checks++; if (obs_ok !== 1'b1 || obs_rsp_data !== EMPTY) begin n_fail++; $display("FAIL inflight_readback: got ok %b data %h expected ok 1 data ffffffff", obs_ok, obs_rsp_data); end
    endtask

    task automatic test_saturation;
        // Cell 10 holds 5; every claim fails. 15 saturates a 4-bit counter.
        for (int i = 1; i <= 18; i++) begin
            do_op(i % 4, OP_CLAIM, 12'd10, 32'd200);
            if (i == 14) begin
                n_checks++; if (conflict_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_mid: got %0d expected 14", conflict_cnt); end
            end
        end
        n_checks++; if (conflict_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h expected f", conflict_cnt); end
        n_checks++; if (obs_ok !== 1'b0 || obs_rsp_data !== 32'd5) begin n_fail++; $display("FAIL sat_last_rsp: got ok %b data %0d expected ok 0 data 5", obs_ok, obs_rsp_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_claim_empty();
        test_claim_occupied();
        test_back_to_back();
        test_out_of_range();
        test_reset_in_flight();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
